// File: rtl/chip8_exec_unit.sv
// Chip-8 register file + ALU for 6XNN/7XNN/8XYn with valid/ready intake.
// Optional: define CHIP8_SHIFT_VY_EN for COSMAC shifts (VX = VY shifted).
module chip8_exec_unit #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 16,
  parameter int NUM_DBG  = 2
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_reset_n,
  input  logic [15:0]                instr_i,
  input  logic                       instr_valid_i,
  output logic                       instr_ready_o,
  output logic                       done_o,
  output logic                       err_o,
  input  logic [NUM_DBG*4-1:0]       dbg_sel_i,
  output logic [NUM_DBG*DATA_W-1:0]  dbg_data_o
);

  localparam int IW = $clog2(NUM_REGS);
  localparam int FI = NUM_REGS - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_FLAG,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [15:0]       instr_q, instr_d;
  logic              flag_q, flag_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic [IW-1:0]     x_idx;
  logic [IW-1:0]     y_idx;
  logic [DATA_W-1:0] vx;
  logic [DATA_W-1:0] vy;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] sh_src;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] res;
  logic              flag_v;
  logic              flag_op;
  logic              illegal;

  assign x_idx = instr_q[8 +: IW];
  assign y_idx = instr_q[4 +: IW];
  assign vx    = regs_q[x_idx];
  assign vy    = regs_q[y_idx];
  assign imm   = DATA_W'(instr_q[7:0]);
  assign sum   = {1'b0, vx} + {1'b0, vy};

`ifdef CHIP8_SHIFT_VY_EN
  assign sh_src = vy;
`else
  assign sh_src = vx;
`endif

  always_comb begin
    res     = '0;
    flag_v  = 1'b0;
    flag_op = 1'b0;
    illegal = 1'b0;
    unique case (instr_q[15:12])
      4'h6: res = imm;
      4'h7: res = vx + imm;
      4'h8: begin
        unique case (instr_q[3:0])
          4'h0: res = vy;
          4'h1: res = vx | vy;
          4'h2: res = vx & vy;
          4'h3: res = vx ^ vy;
          4'h4: begin
            res     = sum[DATA_W-1:0];
            flag_v  = sum[DATA_W];
            flag_op = 1'b1;
          end
          4'h5: begin
            res     = vx - vy;
            flag_v  = (vx >= vy);
            flag_op = 1'b1;
          end
          4'h6: begin
            res     = sh_src >> 1;
            flag_v  = sh_src[0];
            flag_op = 1'b1;
          end
          4'h7: begin
            res     = vy - vx;
            flag_v  = (vy >= vx);
            flag_op = 1'b1;
          end
          4'hE: begin
            res     = sh_src << 1;
            flag_v  = sh_src[DATA_W-1];
            flag_op = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    flag_d        = flag_q;
    err_d         = err_q;
    instr_ready_o = 1'b0;
    done_o        = 1'b0;
    err_o         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i) begin
          instr_d = instr_i;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        flag_d  = flag_v;
        err_d   = illegal;
        state_d = (flag_op && !illegal) ? S_FLAG : S_DONE;
      end
      S_FLAG: state_d = S_DONE;
      S_DONE: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
      // VX lands in EXEC; a later FLAG write wins when X is the flag index
      if (state_q == S_EXEC && !illegal) begin
        regs_q[x_idx] <= res;
      end else if (state_q == S_FLAG) begin
        regs_q[FI] <= DATA_W'(flag_q);
      end
    end
  end

  for (genvar g = 0; g < NUM_DBG; g++) begin : g_dbg
    assign dbg_data_o[g*DATA_W +: DATA_W] = regs_q[dbg_sel_i[g*4 +: IW]];
  end

endmodule
